slave_fifo_stream_in: RTL

Parametrised stream-in controller that moves ADC samples into the USB bridge's slave FIFO. It buffers samples from the ADC front end in a small internal FIFO and packs each sample into the bus word, marking the first word of each capture. It writes to the bridge whenever the partial flag allows, then closes a capture with a short-packet commit (pktend) after a stop request. It sits between the ADC capture logic and the slave-FIFO pins, replacing the fixed two-state writer.

---
 rtl/slave_fifo_pkg.sv | 18 +
 rtl/slave_fifo_stream_in_if.sv | 35 +++
 rtl/sync_fifo_buf.sv | 66 ++++++
 rtl/slave_fifo_stream_in.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/slave_fifo_pkg.sv
// Shared types and constants for the slave-FIFO stream-in controller.
// State encoding, default socket and active-low strobe levels.
package slave_fifo_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STREAM = 3'd1,
    FLUSH  = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [1:0] SOCKET_DEF = 2'b10;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/slave_fifo_stream_in_if.sv
// Slave-FIFO pin bundle between the stream-in controller and the bridge.
// master = controller side, slave = bridge side.
interface slave_fifo_stream_in_if #(
  parameter int BUS_W = 16
);

  logic [BUS_W-1:0] fdata;
  logic [1:0]       faddr;
  logic             slwr;
  logic             slrd;
  logic             sloe;
  logic             pktend;
  logic             flagd;

  modport master (
    output fdata,
    output faddr,
    output slwr,
    output slrd,
    output sloe,
    output pktend,
    input  flagd
  );

  modport slave (
    input  fdata,
    input  faddr,
    input  slwr,
    input  slrd,
    input  sloe,
    input  pktend,
    output flagd
  );

endinterface

// File: rtl/sync_fifo_buf.sv
// Small synchronous sample buffer with registered read data.
// A push on full is accepted when a pop happens in the same cycle.
module sync_fifo_buf
  import slave_fifo_pkg::*;
#(
  parameter int W     = 12,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic [W-1:0] rdata_q, rdata_d;
  logic         do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = rdata_q;

  // Pointer advance and read-data capture; clear wins over everything.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
    rdata_d = do_pop ? mem_q[rptr_q[AW-1:0]] : rdata_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  // Pointer and read-data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array; contents need no reset since pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/slave_fifo_stream_in.sv
// ADC stream-in controller for the USB bridge slave FIFO.
// Buffers samples, packs bus words, and closes captures with pktend.
module slave_fifo_stream_in
  import slave_fifo_pkg::*;
#(
  parameter int         ADC_W     = 12,
  parameter int         BUS_W     = 16,
  parameter int         PKT_WORDS = 512,
  parameter int         BUF_DEPTH = 16,
  parameter logic [1:0] SOCKET    = SOCKET_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sync,
  input  logic                  stop,
  input  logic [ADC_W-1:0]      adc_data,
  input  logic                  adc_valid,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           overflow_cnt,
  slave_fifo_stream_in_if.master fifo
);

  localparam int WCW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [WCW-1:0] WC_LAST = WCW'(PKT_WORDS - 1);

  state_e           state_q, state_d;
  logic [WCW-1:0]   word_cnt_q, word_cnt_d;
  logic [15:0]      ovf_q, ovf_d;
  logic             first_q, first_d;
  logic             pend_q, pend_d;
  logic [BUS_W-1:0] fdata_q, fdata_d;
  logic             slwr_q, slwr_d;
  logic             pktend_q, pktend_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             buf_clr, buf_push, buf_pop;
  logic             buf_full, buf_empty;
  logic [ADC_W-1:0] buf_rdata;
  logic [BUS_W-1:0] word;
  logic             streaming, draining;

  assign streaming = (state_q == STREAM);
  assign draining  = streaming || (state_q == FLUSH);

  sync_fifo_buf #(
    .W     (ADC_W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .clr   (buf_clr),
    .push  (buf_push),
    .pop   (buf_pop),
    .wdata (adc_data),
    .rdata (buf_rdata),
    .full  (buf_full),
    .empty (buf_empty)
  );

  // Next state, buffer control, word packing and counters.
  // A pop registers the sample; the following cycle drives it out.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    ovf_d      = ovf_q;
    first_d    = first_q;
    fdata_d    = fdata_q;
    slwr_d     = STROBE_OFF;
    buf_clr    = 1'b0;
    word       = '0;

    buf_pop  = draining && !buf_empty && fifo.flagd;
    buf_push = streaming && adc_valid && (!buf_full || buf_pop);
    pend_d   = buf_pop;

    if (streaming && adc_valid && buf_full && !buf_pop &&
        ovf_q != 16'hFFFF) begin
      ovf_d = ovf_q + 16'd1;
    end

    if (pend_q) begin
      word[ADC_W-1:0] = buf_rdata;
      word[BUS_W-1]   = first_q;
      fdata_d         = word;
      slwr_d          = STROBE_ON;
      first_d         = 1'b0;
      word_cnt_d      = (word_cnt_q == WC_LAST) ? '0
                                                : word_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (sync) begin
          state_d    = STREAM;
          word_cnt_d = '0;
          ovf_d      = '0;
          first_d    = 1'b1;
          buf_clr    = 1'b1;
        end
      end
      STREAM: begin
        if (stop) state_d = FLUSH;
      end
      FLUSH: begin
        if (buf_empty && !pend_q) begin
          state_d = (word_cnt_d != '0) ? COMMIT : DONE;
        end
      end
      COMMIT:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pktend_d = (state_d == COMMIT) ? STROBE_ON : STROBE_OFF;
    done_d   = (state_d == DONE);
    busy_d   = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      ovf_q      <= '0;
      first_q    <= 1'b0;
      pend_q     <= 1'b0;
      fdata_q    <= '0;
      slwr_q     <= STROBE_OFF;
      pktend_q   <= STROBE_OFF;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      ovf_q      <= ovf_d;
      first_q    <= first_d;
      pend_q     <= pend_d;
      fdata_q    <= fdata_d;
      slwr_q     <= slwr_d;
      pktend_q   <= pktend_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign fifo.fdata   = fdata_q;
  assign fifo.faddr   = SOCKET;
  assign fifo.slwr    = slwr_q;
  assign fifo.slrd    = STROBE_OFF;
  assign fifo.sloe    = STROBE_OFF;
  assign fifo.pktend  = pktend_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow_cnt = ovf_q;

endmodule
